// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU sequencer.
package cpu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int OP_W_DEF   = 4;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JMI = 4'd5;
    localparam logic [3:0] OP_JEQ = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;

    // Anything above the last defined opcode stops the machine.
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_LDI;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/status bundle between the sequencer and its environment.
// STEP exists only when CPU_SEQUENCER_SINGLE_STEP_EN is defined.
interface cpu_sequencer_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic                     RUN;
    logic [DATA_W-1:0]        MEM_Q;
    logic [DATA_W-1:0]        ACC;
    logic                     EXTRA;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic                     STEP;
`endif
    logic                     FETCH;
    logic                     EXEC1;
    logic                     EXEC2;
    logic [OP_W-1:0]          IR;
    logic [DATA_W-OP_W-1:0]   OPERAND;
    logic                     EQ;
    logic                     MI;
    logic                     HALTED;
    logic                     ILLEGAL;
    logic [CNT_W-1:0]         RETIRED;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    modport master (output RUN, MEM_Q, ACC, EXTRA, STEP,
                    input  FETCH, EXEC1, EXEC2, IR, OPERAND, EQ, MI, HALTED, ILLEGAL, RETIRED);
    modport slave  (input  RUN, MEM_Q, ACC, EXTRA, STEP,
                    output FETCH, EXEC1, EXEC2, IR, OPERAND, EQ, MI, HALTED, ILLEGAL, RETIRED);
`else
    modport master (output RUN, MEM_Q, ACC, EXTRA,
                    input  FETCH, EXEC1, EXEC2, IR, OPERAND, EQ, MI, HALTED, ILLEGAL, RETIRED);
    modport slave  (input  RUN, MEM_Q, ACC, EXTRA,
                    output FETCH, EXEC1, EXEC2, IR, OPERAND, EQ, MI, HALTED, ILLEGAL, RETIRED);
`endif

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_sequencer.sv
// FETCH/EXEC1/EXEC2 phase generator, IR latch, condition flags and retire counter.
// Optional single-step launch via STEP under CPU_SEQUENCER_SINGLE_STEP_EN.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic            CLK,
    input  logic            RESET_N,
    cpu_sequencer_if.slave  bus
);
    state_e                 state_q, state_d;
    logic [OP_W-1:0]        ir_q, ir_d;
    logic [DATA_W-OP_W-1:0] opnd_q, opnd_d;
    logic                   ill_q, ill_d;
    logic                   retire;
    logic                   step_go;

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    logic step_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) step_q <= 1'b0;
        else          step_q <= bus.STEP;
    end

    // Only consulted in IDLE, so edges mid-instruction are simply dropped.
    assign step_go = bus.STEP & ~step_q;
`else
    assign step_go = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        opnd_d  = opnd_q;
        ill_d   = ill_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.RUN || step_go)
                    state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EXEC1;
                ir_d    = bus.MEM_Q[DATA_W-1 -: OP_W];
                opnd_d  = bus.MEM_Q[DATA_W-OP_W-1:0];
            end
            S_EXEC1: begin
                if (ir_q == OP_W'(OP_STP)) begin
                    state_d = S_HALT;
                end else if (is_illegal(4'(ir_q))) begin
                    state_d = S_HALT;
                    ill_d   = 1'b1;
                end else if (bus.EXTRA) begin
                    state_d = S_EXEC2;
                end else begin
                    retire  = 1'b1;
                    state_d = bus.RUN ? S_FETCH : S_IDLE;
                end
            end
            S_EXEC2: begin
                retire  = 1'b1;
                state_d = bus.RUN ? S_FETCH : S_IDLE;
            end
            S_HALT: ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            opnd_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            opnd_q  <= opnd_d;
            ill_q   <= ill_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_retired (
        .clk   (CLK),
        .rst_n (RESET_N),
        .en_i  (retire),
        .cnt_o (bus.RETIRED)
    );

    assign bus.FETCH   = (state_q == S_FETCH);
    assign bus.EXEC1   = (state_q == S_EXEC1);
    assign bus.EXEC2   = (state_q == S_EXEC2);
    assign bus.HALTED  = (state_q == S_HALT);
    assign bus.ILLEGAL = ill_q;
    assign bus.IR      = ir_q;
    assign bus.OPERAND = opnd_q;
    assign bus.EQ      = (bus.ACC == '0);
    assign bus.MI      = bus.ACC[DATA_W-1];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a 16-bit-counter DUT plus a 2-bit-counter
// twin on the same stimulus to exercise counter saturation.
module tb_cpu_sequencer;
    logic CLK, RESET_N;
    int   n_run  = 0;
    int   n_fail = 0;
    int   exp_ret = 0;
    logic [15:0] sb_q[$];

    cpu_sequencer_if #(.DATA_W(16), .OP_W(4), .CNT_W(16)) bus ();
    cpu_sequencer_if #(.DATA_W(16), .OP_W(4), .CNT_W(2))  bus2 ();

    assign bus2.RUN   = bus.RUN;
    assign bus2.MEM_Q = bus.MEM_Q;
    assign bus2.ACC   = bus.ACC;
    assign bus2.EXTRA = bus.EXTRA;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
    assign bus2.STEP  = bus.STEP;
`endif

    cpu_sequencer #(.DATA_W(16), .OP_W(4), .CNT_W(16)) dut  (.CLK(CLK), .RESET_N(RESET_N), .bus(bus));
    cpu_sequencer #(.DATA_W(16), .OP_W(4), .CNT_W(2))  dut2 (.CLK(CLK), .RESET_N(RESET_N), .bus(bus2));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [2:0] phases();
        return {bus.FETCH, bus.EXEC1, bus.EXEC2};
    endfunction

    function automatic logic [31:0] sat2(input int v);
        return (v > 3) ? 32'd3 : 32'(v);
    endfunction

    // Entered while in FETCH; runs one legal instruction through its retire edge.
    task automatic instr(input logic [15:0] mem, input logic extra, input logic run_nxt);
        logic [15:0] e;
        chk("pre_fetch", 32'(phases()), 32'b100);
        bus.MEM_Q = mem;
        bus.EXTRA = extra;
        sb_q.push_back(mem);
        cyc();
        e = sb_q.pop_front();
        chk("exec1", 32'(phases()), 32'b010);
        chk("ir", 32'(bus.IR), 32'(e[15:12]));
        chk("operand", 32'(bus.OPERAND), 32'(e[11:0]));
        if (extra) begin
            cyc();
            chk("exec2", 32'(phases()), 32'b001);
            chk("ret_pre", 32'(bus.RETIRED), 32'(exp_ret));
        end
        bus.RUN = run_nxt;
        cyc();
        exp_ret++;
        chk("retired", 32'(bus.RETIRED), 32'(exp_ret));
        chk("retired_sat", 32'(bus2.RETIRED), sat2(exp_ret));
        chk("after_ret", 32'(phases()), run_nxt ? 32'b100 : 32'b000);
        bus.EXTRA = 1'b0;
    endtask

    initial begin
        int bad;
        logic [15:0] e;
        RESET_N   = 1'b0;
        bus.RUN   = 1'b0;
        bus.MEM_Q = '0;
        bus.ACC   = '0;
        bus.EXTRA = 1'b0;
`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        bus.STEP  = 1'b0;
`endif
        repeat (2) cyc();
        chk("rst_phase", 32'(phases()), 32'b000);
        chk("rst_flags", 32'({bus.HALTED, bus.ILLEGAL}), 32'b00);
        chk("rst_ir_op", 32'({bus.IR, bus.OPERAND}), 32'h0);
        chk("rst_ret", 32'(bus.RETIRED), 32'h0);

        // ADD with EXTRA: FETCH, EXEC1, EXEC2, retire
        bus.RUN = 1'b1;
        RESET_N = 1'b1;
        cyc();
        chk("t1_fetch", 32'(phases()), 32'b100);
        instr(16'h2005, 1'b1, 1'b1);

        // back-to-back one-phase STA instructions
        repeat (4) instr(16'h1010, 1'b0, 1'b1);
        chk("t2_count", 32'(bus.RETIRED), 32'd5);

        // flags
        bus.ACC = 16'h0000; #1;
        chk("eq_zero", 32'({bus.EQ, bus.MI}), 32'b10);
        bus.ACC = 16'h8001; #1;
        chk("mi_neg", 32'({bus.EQ, bus.MI}), 32'b01);
        bus.ACC = 16'h0001; #1;
        chk("pos", 32'({bus.EQ, bus.MI}), 32'b00);

        // STP halts, RUN ignored, nothing retires
        bus.MEM_Q = 16'h7000;
        sb_q.push_back(16'h7000);
        cyc();
        e = sb_q.pop_front();
        chk("stp_ir", 32'(bus.IR), 32'(e[15:12]));
        cyc();
        chk("stp_halt", 32'({bus.HALTED, bus.ILLEGAL}), 32'b10);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (phases() != 3'b000 || !bus.HALTED || bus.RETIRED != 16'(exp_ret)) bad++;
        end
        chk("stp_hold", 32'(bad), 32'd0);

        RESET_N = 1'b0; #1;
        exp_ret = 0;
        chk("rst2_halt", 32'(bus.HALTED), 32'd0);
        chk("rst2_ret", 32'(bus.RETIRED), 32'd0);

        // LDI is the highest legal opcode; 0xA is illegal
        RESET_N = 1'b1;
        cyc();
        instr(16'h8123, 1'b0, 1'b1);
        bus.MEM_Q = 16'hA000;
        sb_q.push_back(16'hA000);
        cyc();
        e = sb_q.pop_front();
        chk("ill_ir", 32'(bus.IR), 32'(e[15:12]));
        cyc();
        chk("ill_halt", 32'({bus.HALTED, bus.ILLEGAL}), 32'b11);
        chk("ill_ret", 32'(bus.RETIRED), 32'(exp_ret));

        // asynchronous reset away from the clock edge
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        exp_ret = 0;
        chk("async_rst", 32'({phases(), bus.HALTED, bus.ILLEGAL}), 32'd0);
        chk("async_ir", 32'({bus.IR, bus.OPERAND}), 32'd0);
        chk("async_ret", 32'(bus.RETIRED), 32'd0);

        // opcode 9: first illegal value
        @(negedge CLK);
        RESET_N = 1'b1;
        cyc();
        bus.MEM_Q = 16'h9000;
        cyc();
        cyc();
        chk("op9_halt", 32'({bus.HALTED, bus.ILLEGAL}), 32'b11);
        RESET_N = 1'b0; #1;
        RESET_N = 1'b1;

        // RUN dropped during EXEC2: instruction still retires, then IDLE
        cyc();
        instr(16'h3001, 1'b1, 1'b0);
        repeat (3) cyc();
        chk("idle_hold", 32'(phases()), 32'b000);
        bus.RUN = 1'b1;
        cyc();
        repeat (4) instr(16'h0042, 1'b0, 1'b1);
        chk("sat_stuck", 32'(bus2.RETIRED), 32'd3);
        bus.RUN = 1'b0;
        instr(16'h4002, 1'b0, 1'b0);

`ifdef CPU_SEQUENCER_SINGLE_STEP_EN
        // one STEP edge launches exactly one instruction
        bus.STEP = 1'b1;
        cyc();
        instr(16'h1001, 1'b0, 1'b0);
        repeat (3) cyc();
        chk("step_once", 32'(phases()), 32'b000);
        bus.STEP = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
